// File: rtl/shmult_pkg.sv
// Shared definitions for the shift-add multiplier: state encoding, default
// operand width and the step-counter width helper.
package shmult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // Counter must be able to represent WIDTH itself, hence WIDTH+1.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH + 1);

endpackage

// File: rtl/shmult_add_cell.sv
// WIDTH-bit combinational ripple-carry adder producing sum and carry out.
module shmult_add_cell #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic c;

    always_comb begin
        c   = 1'b0;
        sum = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier, one partial product per RUN cycle.
// Optional macro SHMULT_ZERO_SKIP_EN: zero operands finish straight to DONE.
module shift_add_multiplier
    import shmult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               shclk,
    input  logic               shrst_n,
    input  logic               shstart,
    input  logic [WIDTH-1:0]   sha,
    input  logic [WIDTH-1:0]   shb,
    output logic               shready,
    output logic               shbusy,
    output logic               shdone,
    output logic [2*WIDTH-1:0] shproduct,
    output state_t             shstate
);

    // Handshake: a multiply is accepted on a rising edge where shstart and
    // shready are both high; shdone is a single-cycle result-valid strobe.
    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               carry;
    logic [2*WIDTH-1:0] next_acc;
    logic               last_step;

    assign addend    = acc[0] ? mcand : '0;
    assign next_acc  = {carry, sum, acc[WIDTH-1:1]};
    assign last_step = (cnt == CNT_W'(WIDTH - 1));
    assign shstate   = state;

    shmult_add_cell #(.WIDTH(WIDTH)) u_add (
        .a    (acc[2*WIDTH-1:WIDTH]),
        .b    (addend),
        .sum  (sum),
        .cout (carry)
    );

    always_ff @(posedge shclk or negedge shrst_n) begin
        if (!shrst_n) begin
            state     <= IDLE;
            mcand     <= '0;
            acc       <= '0;
            cnt       <= '0;
            shproduct <= '0;
            shready   <= 1'b1;
            shbusy    <= 1'b0;
            shdone    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (shstart) begin
                        mcand <= sha;
                        acc   <= {{WIDTH{1'b0}}, shb};
                        cnt   <= '0;
`ifdef SHMULT_ZERO_SKIP_EN
                        if (sha == '0 || shb == '0) begin
                            state     <= DONE;
                            shproduct <= '0;
                            shready   <= 1'b0;
                            shdone    <= 1'b1;
                        end else begin
                            state   <= RUN;
                            shready <= 1'b0;
                            shbusy  <= 1'b1;
                        end
`else
                        state   <= RUN;
                        shready <= 1'b0;
                        shbusy  <= 1'b1;
`endif
                    end
                end
                RUN: begin
                    acc <= next_acc;
                    cnt <= cnt + CNT_W'(1);
                    if (last_step) begin
                        state     <= DONE;
                        shproduct <= next_acc;
                        shbusy    <= 1'b0;
                        shdone    <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    shdone  <= 1'b0;
                    shready <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    shready <= 1'b1;
                    shbusy  <= 1'b0;
                    shdone  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier (WIDTH=4): vector table,
// corner-case sequences and a shuffled sweep of every operand pair.
module tb_shift_add_multiplier;
    import shmult_pkg::*;

    localparam int W = 4;

    logic           shclk;
    logic           shrst_n;
    logic           shstart;
    logic [W-1:0]   sha;
    logic [W-1:0]   shb;
    logic           shready;
    logic           shbusy;
    logic           shdone;
    logic [2*W-1:0] shproduct;
    state_t         shstate;

    int pass_cnt  = 0;
    int check_cnt = 0;

    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] last_prod;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] prod;
    } vec_t;

    vec_t vecs[10];

    shift_add_multiplier #(.WIDTH(W)) dut (
        .shclk     (shclk),
        .shrst_n   (shrst_n),
        .shstart   (shstart),
        .sha       (sha),
        .shb       (shb),
        .shready   (shready),
        .shbusy    (shbusy),
        .shdone    (shdone),
        .shproduct (shproduct),
        .shstate   (shstate)
    );

    initial shclk = 1'b0;
    always #5 shclk = ~shclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no end, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    function automatic logic [2*W-1:0] model_prod(input logic [W-1:0] a, input logic [W-1:0] b);
        int p;
        p = int'(a) * int'(b);
        return (2*W)'(p);
    endfunction

    // Edges between the accepting edge and the one that raises shdone.
    function automatic int model_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SHMULT_ZERO_SKIP_EN
        if (a == 0 || b == 0) return 0;
`endif
        return W;
    endfunction

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output logic [2*W-1:0] prod);
        logic ok;
        @(negedge shclk);
        sha = a; shb = b; shstart = 1'b1;
        check("ready_idle", shready, 1);
        @(posedge shclk);
        @(negedge shclk);
        shstart = 1'b0;
        sha = W'($urandom);
        shb = W'($urandom);
        lat = 0;
        ok  = 1'b1;
        while (!shdone && lat < 20) begin
            if (shproduct !== last_prod || shready !== 1'b0 || shbusy !== 1'b1) ok = 1'b0;
            @(negedge shclk);
            lat++;
        end
        check("run_stable", ok, 1);
        check("done_seen", shdone, 1);
        prod = shproduct;
        @(negedge shclk);
        check("done_pulse", {shdone, shready, shbusy}, 3'b010);
    endtask

    initial begin
        int lat;
        int n;
        int dn;
        logic [2*W-1:0] prod;
        logic [2*W-1:0] exp;
        logic [2*W-1:0] b2b_prod[3];
        int order[256];

        vecs[0] = '{4'd15, 4'd15, 8'd225};
        vecs[1] = '{4'd9,  4'd6,  8'd54};
        vecs[2] = '{4'd0,  4'd13, 8'd0};
        vecs[3] = '{4'd7,  4'd7,  8'd49};
        vecs[4] = '{4'd1,  4'd1,  8'd1};
        vecs[5] = '{4'd2,  4'd3,  8'd6};
        vecs[6] = '{4'd15, 4'd1,  8'd15};
        vecs[7] = '{4'd4,  4'd4,  8'd16};
        vecs[8] = '{4'd0,  4'd0,  8'd0};
        vecs[9] = '{4'd13, 4'd11, 8'd143};

        // Clock/reset block
        shrst_n = 1'b0; shstart = 1'b0; sha = '0; shb = '0;
        last_prod = '0;
        repeat (3) @(negedge shclk);
        check("reset_flags", {shready, shbusy, shdone}, 3'b100);
        check("reset_product", shproduct, 0);
        check("reset_state", shstate, IDLE);
        shrst_n = 1'b1;

        // Vector table
        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, lat, prod);
            check($sformatf("vec%0d_prod", i), prod, vecs[i].prod);
            check($sformatf("vec%0d_lat", i), lat, model_lat(vecs[i].a, vecs[i].b));
            last_prod = vecs[i].prod;
        end

        // Start request during RUN must be ignored
        @(negedge shclk);
        sha = 4'd7; shb = 4'd7; shstart = 1'b1;
        @(posedge shclk);
        @(negedge shclk);
        shstart = 1'b0;
        @(negedge shclk);
        shstart = 1'b1; sha = 4'd3; shb = 4'd5;
        @(negedge shclk);
        check("busy_ready_low", shready, 0);
        @(negedge shclk);
        shstart = 1'b0;
        n = 3;
        while (!shdone && n < 20) begin
            @(negedge shclk);
            n++;
        end
        check("busy_lat", n, 4);
        check("busy_prod", shproduct, 49);
        dn = 0;
        repeat (10) begin
            @(negedge shclk);
            if (shdone) dn++;
        end
        check("busy_no_second_done", dn, 0);
        check("busy_prod_hold", shproduct, 49);
        last_prod = 8'd49;

        // shstart held high: back-to-back operations
        b2b_prod[0] = 8'd1; b2b_prod[1] = 8'd6; b2b_prod[2] = 8'd15;
        @(negedge shclk);
        sha = 4'd1; shb = 4'd1; shstart = 1'b1;
        @(posedge shclk);
        @(negedge shclk);
        sha = 4'd2; shb = 4'd3;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!shdone && n < 20) begin
                @(negedge shclk);
                n++;
            end
            check($sformatf("b2b%0d_lat", k), n, 4);
            check($sformatf("b2b%0d_prod", k), shproduct, b2b_prod[k]);
            @(negedge shclk);
            check($sformatf("b2b%0d_idle", k), {shdone, shready}, 2'b01);
            if (k == 2) shstart = 1'b0;
            @(negedge shclk);
            if (k < 2) check($sformatf("b2b%0d_accept", k), shready, 0);
            else check("b2b_stop", {shready, shbusy}, 2'b10);
            if (k == 0) begin
                sha = 4'd15; shb = 4'd1;
            end else begin
                sha = W'($urandom); shb = W'($urandom);
            end
        end
        last_prod = 8'd15;

        // Reset asserted two edges into RUN
        @(negedge shclk);
        sha = 4'd9; shb = 4'd9; shstart = 1'b1;
        @(posedge shclk);
        @(negedge shclk);
        shstart = 1'b0;
        @(negedge shclk);
        @(negedge shclk);
        shrst_n = 1'b0;
        #1;
        check("midrst_flags", {shready, shbusy, shdone}, 3'b100);
        check("midrst_product", shproduct, 0);
        check("midrst_state", shstate, IDLE);
        dn = 0;
        repeat (2) begin
            @(negedge shclk);
            if (shdone) dn++;
        end
        shrst_n = 1'b1;
        repeat (6) begin
            @(negedge shclk);
            if (shdone) dn++;
        end
        check("midrst_no_done", dn, 0);
        last_prod = '0;
        do_op(4'd4, 4'd4, lat, prod);
        check("post_rst_prod", prod, 16);
        check("post_rst_lat", lat, 4);
        last_prod = 8'd16;

        // Shuffled sweep of all operand pairs against the scoreboard
        for (int i = 0; i < 256; i++) order[i] = i;
        for (int i = 255; i > 0; i--) begin
            int j;
            int t;
            j = int'($urandom_range(i, 0));
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        for (int i = 0; i < 256; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = W'(order[i] >> 4);
            b = W'(order[i] & 15);
            exp_q.push_back(model_prod(a, b));
            do_op(a, b, lat, prod);
            exp = exp_q.pop_front();
            check($sformatf("sweep_%0dx%0d_prod", a, b), prod, exp);
            check($sformatf("sweep_%0dx%0d_lat", a, b), lat, model_lat(a, b));
            last_prod = exp;
        end

        // Final report
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
